// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the L1-to-L2 memory arbiter: LC-3b bus widths, FSM state
// and the grant-index width helper.
package mem_arbiter_rr_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_mem_data;

  localparam int LC3B_WORD_W = $bits(lc3b_word);
  localparam int LC3B_LINE_W = $bits(lc3b_mem_data);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Keeps the grant index at least one bit wide.
  function automatic int port_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Requester/L2 bundle of the memory arbiter. The arbiter uses the slave view;
// the surrounding caches and L2 together form the master view.
interface mem_arbiter_rr_if
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = LC3B_WORD_W,
  parameter int DATA_WIDTH = LC3B_LINE_W,
  parameter int ID_WIDTH   = port_id_width(NUM_PORTS)
);

  logic [NUM_PORTS-1:0]            req_read;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            req_resp;
  logic [DATA_WIDTH-1:0]           req_rdata;

  logic                            l2_mem_read;
  logic                            l2_mem_write;
  logic [ADDR_WIDTH-1:0]           l2_mem_address;
  logic [DATA_WIDTH-1:0]           l2_mem_wdata;
  logic                            l2_mem_resp;
  logic [DATA_WIDTH-1:0]           l2_mem_rdata;

  logic                            grant_valid;
  logic [ID_WIDTH-1:0]             grant_id;

  modport slave (
    input  req_read, req_write, req_address, req_wdata,
    input  l2_mem_resp, l2_mem_rdata,
    output req_resp, req_rdata,
    output l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata,
    output grant_valid, grant_id
  );

  modport master (
    output req_read, req_write, req_address, req_wdata,
    output l2_mem_resp, l2_mem_rdata,
    input  req_resp, req_rdata,
    input  l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata,
    input  grant_valid, grant_id
  );

endinterface

// File: rtl/mem_arbiter_rr_rr_pick.sv
// Combinational winner selection: rotates the active vector so the scan starts
// just past the previous grant (or at port 0 in fixed priority), then encodes.
module mem_arbiter_rr_rr_pick
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter bit RR_MODE   = 1'b1,
  parameter int ID_WIDTH  = port_id_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] active,
  input  logic [ID_WIDTH-1:0]  last_grant,
  output logic [ID_WIDTH-1:0]  winner,
  output logic                 any_active
);

  int                   start;
  logic [NUM_PORTS-1:0] rot;

  assign any_active = |active;

  always_comb begin
    start  = RR_MODE ? ((int'(last_grant) + 1) % NUM_PORTS) : 0;
    // The doubled vector makes the wrap-around a plain right shift.
    rot    = NUM_PORTS'({active, active} >> start);
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) winner = ID_WIDTH'((start + i) % NUM_PORTS);
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port arbiter in front of the shared L2: picks one requester, holds its
// request on the L2 port for the whole transaction and routes the response back.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = LC3B_WORD_W,
  parameter int DATA_WIDTH = LC3B_LINE_W,
  parameter bit RR_MODE    = 1'b1,
  parameter int ID_WIDTH   = port_id_width(NUM_PORTS)
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_rr_if.slave bus
);

  arb_state_t             state, state_nxt;
  logic [NUM_PORTS-1:0]   active;
  logic [NUM_PORTS-1:0]   resp_vec;
  logic [ID_WIDTH-1:0]    winner, last_grant, grant_id_q;
  logic                   any_active, launch, finish;
  logic                   l2_read_q, l2_write_q, grant_valid_q;
  logic [ADDR_WIDTH-1:0]  l2_addr_q, win_addr;
  logic [DATA_WIDTH-1:0]  l2_wdata_q, win_wdata;

  assign active = bus.req_read | bus.req_write;

  mem_arbiter_rr_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .RR_MODE   (RR_MODE),
    .ID_WIDTH  (ID_WIDTH)
  ) u_pick (
    .active     (active),
    .last_grant (last_grant),
    .winner     (winner),
    .any_active (any_active)
  );

  assign win_addr  = bus.req_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = bus.req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];

  assign launch = (state == ARB_IDLE) && any_active;
  assign finish = (state == ARB_BUSY) && bus.l2_mem_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Leaving BUSY always passes through one IDLE cycle so the finished
  // requester can drop its request before the next arbitration.
  always_comb begin
    state_nxt = state;
    if (state == ARB_IDLE) begin
      if (any_active) state_nxt = ARB_BUSY;
    end else begin
      if (bus.l2_mem_resp) state_nxt = ARB_IDLE;
    end
  end

  always_comb begin
    resp_vec = '0;
    if (state == ARB_BUSY && bus.l2_mem_resp) resp_vec[grant_id_q] = 1'b1;
  end

  // The winner's request is captured once at launch; requester inputs are
  // not looked at again until the transaction completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l2_read_q     <= 1'b0;
      l2_write_q    <= 1'b0;
      l2_addr_q     <= '0;
      l2_wdata_q    <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_grant    <= ID_WIDTH'(NUM_PORTS - 1);
    end else if (launch) begin
      l2_addr_q     <= win_addr;
      l2_wdata_q    <= win_wdata;
      l2_write_q    <= bus.req_write[winner];
      l2_read_q     <= bus.req_read[winner] & ~bus.req_write[winner];
      grant_valid_q <= 1'b1;
      grant_id_q    <= winner;
      last_grant    <= winner;
    end else if (finish) begin
      l2_read_q     <= 1'b0;
      l2_write_q    <= 1'b0;
      grant_valid_q <= 1'b0;
    end
  end

  assign bus.req_resp       = resp_vec;
  assign bus.req_rdata      = bus.l2_mem_rdata;
  assign bus.l2_mem_read    = l2_read_q;
  assign bus.l2_mem_write   = l2_write_q;
  assign bus.l2_mem_address = l2_addr_q;
  assign bus.l2_mem_wdata   = l2_wdata_q;
  assign bus.grant_valid    = grant_valid_q;
  assign bus.grant_id       = grant_id_q;

endmodule
